datamem_arbiter: RTL and testbench

- Shares the single-port data memory (8-bit address, 8-bit data) between two requesters:
  - the processor core's load/store path;
  - a host port used by the bench or loader for preload and readback.
- Sits between the core's memory-access signals and the data memory instance.
- Grants one requester per cycle using round-robin, with an optional bounded host burst lock.
- Returns read data one cycle after grant, together with a valid strobe.

---
 rtl/datamem_arbiter_pkg.sv | 11 +
 rtl/datamem_arbiter_if.sv | 23 ++
 rtl/datamem_arbiter_grant.sv | 46 ++++
 rtl/datamem_arbiter.sv | 122 ++++++++++++
 tb/tb_datamem_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/datamem_arbiter_pkg.sv
// rtl/datamem_arbiter_pkg.sv - shared owner type and burst counter width for the data memory arbiter
package definitions;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } dm_owner_t;

    localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/datamem_arbiter_if.sv
// rtl/datamem_arbiter_if.sv - one requester's view of the shared data memory port
interface datamem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/datamem_arbiter_grant.sv
// rtl/datamem_arbiter_grant.sv - combinational round-robin winner selection with bounded host lock
module dm_arb_grant
    import definitions::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                   core_req,
    input  logic                   host_req,
    input  logic                   host_lock,
    input  dm_owner_t              last_owner,
    input  logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   core_win,
    output logic                   host_win
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

    logic lock_active;

    // Once burst_cnt reaches the limit the lock drops, and the tie rule hands the next slot to the core.
    assign lock_active = (last_owner == OWN_HOST) && host_lock && host_req
                         && (burst_cnt < BURST_LIMIT);

    always_comb begin
        core_win = 1'b0;
        host_win = 1'b0;
        case ({core_req, host_req})
            2'b10: core_win = 1'b1;
            2'b01: host_win = 1'b1;
            2'b11: begin
                if (lock_active) begin
                    host_win = 1'b1;
                end else if (last_owner == OWN_HOST) begin
                    core_win = 1'b1;
                end else begin
                    host_win = 1'b1;
                end
            end
            default: begin
                core_win = 1'b0;
                host_win = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - shares the single-port data memory between the core and the host port
module datamem_arbiter
    import definitions::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

    dm_owner_t              last_owner_q, last_owner_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic                   core_rvalid_q, core_rvalid_d;
    logic                   host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0]      core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0]      host_rdata_q, host_rdata_d;

    logic core_win;
    logic host_win;

    dm_arb_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .core_req   (core_req),
        .host_req   (host_req),
        .host_lock  (host_lock),
        .last_owner (last_owner_q),
        .burst_cnt  (burst_cnt_q),
        .core_win   (core_win),
        .host_win   (host_win)
    );

    assign core_gnt = core_win;
    assign host_gnt = host_win;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_win) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_win) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (core_win) begin
            last_owner_d = OWN_CORE;
        end else if (host_win) begin
            last_owner_d = OWN_HOST;
        end

        // Only a locked host grant that holds off a waiting core counts toward the burst.
        burst_cnt_d = '0;
        if (host_win && core_req && host_lock) begin
            burst_cnt_d = (burst_cnt_q >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt_q + 1'b1;
        end
    end

    always_comb begin
        core_rvalid_d = core_win && !core_we;
        host_rvalid_d = host_win && !host_we;
        core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
        host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_owner_q  <= OWN_HOST;
            burst_cnt_q   <= '0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            last_owner_q  <= last_owner_d;
            burst_cnt_q   <= burst_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign core_rvalid = core_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - directed cycle-table bench for datamem_arbiter
module tb_datamem_arbiter;

    logic       clock;
    logic       reset_n;
    logic       host_lock;
    logic       mem_load;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] mem_arr [256];

    datamem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) core_bus ();
    datamem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) host_bus ();

    datamem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .core_req    (core_bus.req),
        .core_we     (core_bus.we),
        .core_addr   (core_bus.addr),
        .core_wdata  (core_bus.wdata),
        .core_gnt    (core_bus.gnt),
        .core_rvalid (core_bus.rvalid),
        .core_rdata  (core_bus.rdata),
        .host_req    (host_bus.req),
        .host_we     (host_bus.we),
        .host_addr   (host_bus.addr),
        .host_wdata  (host_bus.wdata),
        .host_lock   (host_lock),
        .host_gnt    (host_bus.gnt),
        .host_rvalid (host_bus.rvalid),
        .host_rdata  (host_bus.rdata),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: preload each location with addr ^ 0xA5.
    assign mem_rdata = mem_arr[mem_addr];
    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i) ^ 8'hA5;
        end else if (mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic       rst;
        logic       creq; logic cwe; logic [7:0] caddr; logic [7:0] cwd;
        logic       hreq; logic hwe; logic [7:0] haddr; logic [7:0] hwd; logic hlock;
        logic       e_cg; logic e_hg; logic e_mwe; logic [7:0] e_maddr; logic [7:0] e_mwd;
        logic       e_crv; logic e_hrv;
        logic       c_crd; logic [7:0] e_crd;
        logic       c_hrd; logic [7:0] e_hrd;
    } vec_t;

    vec_t vecs [24];
    int   n_cmp;
    int   n_bad;
    int   cur;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL step%0d %s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    task automatic drive_idle();
        core_bus.req = 0; core_bus.we = 0; core_bus.addr = 0; core_bus.wdata = 0;
        host_bus.req = 0; host_bus.we = 0; host_bus.addr = 0; host_bus.wdata = 0;
        host_lock = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cur = -1;
        drive_idle();
        reset_n = 0;
        mem_load = 1;

        //          rst creq we addr   wd     hreq we addr   wd     lk  cg hg mwe maddr  mwd    crv hrv ccrd crd  chrd hrd
        vecs[0]  = '{0, 1,1,8'h10,8'h5A, 0,0,8'h00,8'h00,0, 1,0,1,8'h10,8'h5A, 0,0, 0,8'h00, 0,8'h00};
        vecs[1]  = '{0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00,0, 1,0,0,8'h10,8'h00, 0,0, 0,8'h00, 0,8'h00};
        vecs[2]  = '{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h00,8'h00, 1,0, 1,8'h5A, 0,8'h00};
        vecs[3]  = '{1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h00,8'h00, 0,0, 0,8'h00, 0,8'h00};
        vecs[4]  = '{0, 1,0,8'h30,8'h00, 1,0,8'h40,8'h00,0, 1,0,0,8'h30,8'h00, 0,0, 0,8'h00, 0,8'h00};
        vecs[5]  = '{0, 1,0,8'h31,8'h00, 1,0,8'h40,8'h00,0, 0,1,0,8'h40,8'h00, 1,0, 1,8'h95, 0,8'h00};
        vecs[6]  = '{0, 1,0,8'h31,8'h00, 1,0,8'h41,8'h00,0, 1,0,0,8'h31,8'h00, 0,1, 0,8'h00, 1,8'hE5};
        vecs[7]  = '{0, 1,0,8'h32,8'h00, 1,0,8'h41,8'h00,0, 0,1,0,8'h41,8'h00, 1,0, 1,8'h94, 0,8'h00};
        vecs[8]  = '{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h00,8'h00, 0,1, 0,8'h00, 1,8'hE4};
        vecs[9]  = '{0, 1,0,8'h20,8'h00, 1,0,8'h00,8'h00,1, 0,1,0,8'h00,8'h00, 0,0, 0,8'h00, 0,8'h00};
        vecs[10] = '{0, 1,0,8'h20,8'h00, 1,0,8'h01,8'h00,1, 0,1,0,8'h01,8'h00, 0,1, 0,8'h00, 1,8'hA5};
        vecs[11] = '{0, 1,0,8'h20,8'h00, 1,0,8'h02,8'h00,1, 0,1,0,8'h02,8'h00, 0,1, 0,8'h00, 1,8'hA4};
        vecs[12] = '{0, 1,0,8'h20,8'h00, 1,0,8'h03,8'h00,1, 0,1,0,8'h03,8'h00, 0,1, 0,8'h00, 1,8'hA7};
        vecs[13] = '{0, 1,0,8'h20,8'h00, 1,0,8'h04,8'h00,1, 1,0,0,8'h20,8'h00, 0,1, 0,8'h00, 1,8'hA6};
        vecs[14] = '{0, 0,0,8'h00,8'h00, 1,0,8'h04,8'h00,1, 0,1,0,8'h04,8'h00, 1,0, 1,8'h85, 0,8'h00};
        vecs[15] = '{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h00,8'h00, 0,1, 0,8'h00, 1,8'hA1};
        vecs[16] = '{1, 0,0,8'h00,8'h00, 1,0,8'h50,8'h00,0, 0,1,0,8'h50,8'h00, 0,0, 0,8'h00, 0,8'h00};
        vecs[17] = '{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h00,8'h00, 0,0, 1,8'h00, 1,8'h00};
        vecs[18] = '{0, 1,0,8'h60,8'h00, 1,0,8'h61,8'h00,0, 1,0,0,8'h60,8'h00, 0,0, 0,8'h00, 0,8'h00};
        vecs[19] = '{0, 0,0,8'h00,8'h00, 1,0,8'h61,8'h00,0, 0,1,0,8'h61,8'h00, 1,0, 1,8'hC5, 0,8'h00};
        vecs[20] = '{0, 0,0,8'h00,8'h00, 1,1,8'h7F,8'hC3,0, 0,1,1,8'h7F,8'hC3, 0,1, 0,8'h00, 1,8'hC4};
        vecs[21] = '{0, 1,0,8'h7F,8'h00, 0,0,8'h00,8'h00,0, 1,0,0,8'h7F,8'h00, 0,0, 0,8'h00, 1,8'hC4};
        vecs[22] = '{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h00,8'h00, 1,0, 1,8'hC3, 0,8'h00};
        vecs[23] = '{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h00,8'h00, 0,0, 1,8'hC3, 1,8'hC4};

        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;
        mem_load = 0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle core_gnt",    {7'd0, core_bus.gnt},    8'h00);
            check("idle host_gnt",    {7'd0, host_bus.gnt},    8'h00);
            check("idle core_rvalid", {7'd0, core_bus.rvalid}, 8'h00);
            check("idle host_rvalid", {7'd0, host_bus.rvalid}, 8'h00);
            check("idle core_rdata",  core_bus.rdata,          8'h00);
            check("idle host_rdata",  host_bus.rdata,          8'h00);
            check("idle mem_we",      {7'd0, mem_we},          8'h00);
        end

        for (int i = 0; i < 24; i++) begin
            @(posedge clock);
            #1;
            cur = i;
            reset_n        = !vecs[i].rst;
            core_bus.req   = vecs[i].creq;
            core_bus.we    = vecs[i].cwe;
            core_bus.addr  = vecs[i].caddr;
            core_bus.wdata = vecs[i].cwd;
            host_bus.req   = vecs[i].hreq;
            host_bus.we    = vecs[i].hwe;
            host_bus.addr  = vecs[i].haddr;
            host_bus.wdata = vecs[i].hwd;
            host_lock      = vecs[i].hlock;
            @(negedge clock);
            check("core_gnt",    {7'd0, core_bus.gnt},    {7'd0, vecs[i].e_cg});
            check("host_gnt",    {7'd0, host_bus.gnt},    {7'd0, vecs[i].e_hg});
            check("mem_we",      {7'd0, mem_we},          {7'd0, vecs[i].e_mwe});
            check("mem_addr",    mem_addr,                vecs[i].e_maddr);
            check("mem_wdata",   mem_wdata,               vecs[i].e_mwd);
            check("core_rvalid", {7'd0, core_bus.rvalid}, {7'd0, vecs[i].e_crv});
            check("host_rvalid", {7'd0, host_bus.rvalid}, {7'd0, vecs[i].e_hrv});
            check("rvalid exclusive", {7'd0, core_bus.rvalid & host_bus.rvalid}, 8'h00);
            if (vecs[i].c_crd) check("core_rdata", core_bus.rdata, vecs[i].e_crd);
            if (vecs[i].c_hrd) check("host_rdata", host_bus.rdata, vecs[i].e_hrd);
        end

        @(posedge clock);
        #1;
        reset_n = 1;
        drive_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
